// File: rtl/data_mem_ctrl_pkg.sv
// Shared opcodes, access sizes, FSM state codes and bus-field bundle for the
// MEM-stage data-memory controller.
package data_mem_ctrl_pkg;

   // MIPS load/store opcodes (instr[31:26])
   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SW  = 6'h2B;

   // Bus access size encoding
   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

   // Controller state encodings (kept as plain 2-bit codes)
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_HOLD = 2'd3;

   // Request fields latched at transaction start and frozen until the next one
   typedef struct packed {
      logic        wr;
      logic [1:0]  size;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } bus_fields_t;

   function automatic logic op_is_store(input logic [5:0] op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/data_mem_ctrl_mem_lane_sel.sv
// Byte-lane steering for one load/store: write strobes, replicated store
// data, access size, load extraction/extension and alignment checks.
module mem_lane_sel
   import data_mem_ctrl_pkg::*;
(
   input  logic [5:0]  op_i,
   input  logic [1:0]  a_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  wstrb_o,
   output logic [31:0] wdata_o,
   output logic [1:0]  size_o,
   output logic [31:0] readdata_o,
   output logic        adel_o,
   output logic        ades_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the addressed byte and halfword out of the returned word
   always_comb begin
      case (a_i)
         2'd0:    byte_sel = rdata_i[7:0];
         2'd1:    byte_sel = rdata_i[15:8];
         2'd2:    byte_sel = rdata_i[23:16];
         default: byte_sel = rdata_i[31:24];
      endcase
      half_sel = a_i[1] ? rdata_i[31:16] : rdata_i[15:0];
   end

   // Per-opcode lane control, extension and misalignment detection
   always_comb begin
      wstrb_o    = 4'b0000;
      wdata_o    = wdata_i;
      size_o     = SIZE_W;
      readdata_o = rdata_i;
      adel_o     = 1'b0;
      ades_o     = 1'b0;
      case (op_i)
         OP_SB: begin
            wstrb_o = 4'b0001 << a_i;
            wdata_o = {4{wdata_i[7:0]}};
            size_o  = SIZE_B;
         end
         OP_SH: begin
            wstrb_o = a_i[1] ? 4'b1100 : 4'b0011;
            wdata_o = {2{wdata_i[15:0]}};
            size_o  = SIZE_H;
            ades_o  = a_i[0];
         end
         OP_SW: begin
            wstrb_o = 4'b1111;
            ades_o  = |a_i;
         end
         OP_LB: begin
            size_o     = SIZE_B;
            readdata_o = {{24{byte_sel[7]}}, byte_sel};
         end
         OP_LBU: begin
            size_o     = SIZE_B;
            readdata_o = {24'h000000, byte_sel};
         end
         OP_LH: begin
            size_o     = SIZE_H;
            readdata_o = {{16{half_sel[15]}}, half_sel};
            adel_o     = a_i[0];
         end
         OP_LHU: begin
            size_o     = SIZE_H;
            readdata_o = {16'h0000, half_sel};
            adel_o     = a_i[0];
         end
         OP_LW: begin
            adel_o = |a_i;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data-memory controller: turns one load/store in M into a single
// req/addr_ok/data_ok bus transaction, stalls the pipe while it is in flight
// and holds the extended load result until M advances.
module data_mem_ctrl
   import data_mem_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        opM,
   input  logic              memenM,
   input  logic [31:0]       aluoutM,
   input  logic [31:0]       writedataM,
   input  logic              flushM,
   input  logic              stall_otherM,
   output logic              data_req,
   output logic              data_wr,
   output logic [1:0]        data_size,
   output logic [ADDR_W-1:0] data_addr,
   output logic [3:0]        data_wstrb,
   output logic [31:0]       data_wdata,
   input  logic              data_addr_ok,
   input  logic              data_data_ok,
   input  logic [31:0]       data_rdata,
   output logic              stallM,
   output logic [31:0]       readdataM,
   output logic              adelM,
   output logic              adesM
);

   logic [1:0]        state_q, state_d;
   logic              flush_pend_q, flush_pend_d;
   logic              req_q, req_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   bus_fields_t       bus_q, bus_d;
   logic [31:0]       rdata_q, rdata_d;

   logic [3:0]  lane_wstrb;
   logic [31:0] lane_wdata;
   logic [1:0]  lane_size;
   logic [31:0] lane_readdata;
   logic        lane_adel;
   logic        lane_ades;
   logic        start;
   logic        capture;

   mem_lane_sel u_lane_sel (
      .op_i       (opM),
      .a_i        (aluoutM[1:0]),
      .wdata_i    (writedataM),
      .rdata_i    (data_rdata),
      .wstrb_o    (lane_wstrb),
      .wdata_o    (lane_wdata),
      .size_o     (lane_size),
      .readdata_o (lane_readdata),
      .adel_o     (lane_adel),
      .ades_o     (lane_ades)
   );

   // Address errors go straight to the exception unit; a faulting or flushed op never starts
   always_comb begin
      adelM  = memenM & lane_adel;
      adesM  = memenM & lane_ades;
      start  = (state_q == ST_IDLE) & memenM & ~lane_adel & ~lane_ades & ~flushM;
      stallM = start | (state_q == ST_REQ) | (state_q == ST_WAIT);
   end

   // Transaction sequencing, field latching, flush tracking and result capture
   always_comb begin
      state_d      = state_q;
      flush_pend_d = flush_pend_q;
      req_d        = req_q;
      addr_d       = addr_q;
      bus_d        = bus_q;
      rdata_d      = rdata_q;
      capture      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d     = ST_REQ;
               req_d       = 1'b1;
               addr_d      = aluoutM[ADDR_W-1:0];
               bus_d.wr    = op_is_store(opM);
               bus_d.size  = lane_size;
               bus_d.wstrb = lane_wstrb;
               bus_d.wdata = lane_wdata;
            end
         end
         ST_REQ: begin
            if (flushM) flush_pend_d = 1'b1;
            if (data_addr_ok) begin
               req_d = 1'b0;
               if (data_data_ok) capture = 1'b1;
               else              state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (flushM) flush_pend_d = 1'b1;
            if (data_data_ok) capture = 1'b1;
         end
         ST_HOLD: begin
            if (!stall_otherM) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // A flush seen at any point of the transaction, including the
      // completing cycle itself, drops the response and skips HOLD.
      if (capture) begin
         if (flush_pend_q | flushM) begin
            state_d = ST_IDLE;
         end else begin
            state_d = ST_HOLD;
            if (!bus_q.wr) rdata_d = lane_readdata;
         end
      end
      if (state_d == ST_IDLE) flush_pend_d = 1'b0;
   end

   // State and bus registers, asynchronously cleared
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         flush_pend_q <= 1'b0;
         req_q        <= 1'b0;
         addr_q       <= '0;
         bus_q        <= '0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         flush_pend_q <= flush_pend_d;
         req_q        <= req_d;
         addr_q       <= addr_d;
         bus_q        <= bus_d;
         rdata_q      <= rdata_d;
      end
   end

   // Drive the bus and pipeline outputs from the registers
   always_comb begin
      data_req   = req_q;
      data_wr    = bus_q.wr;
      data_size  = bus_q.size;
      data_addr  = addr_q;
      data_wstrb = bus_q.wstrb;
      data_wdata = bus_q.wdata;
      readdataM  = rdata_q;
   end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed spec vectors plus randomized
// accesses against a byte-arithmetic reference model.
module tb_data_mem_ctrl;

   localparam logic [5:0] T_LB = 6'h20, T_LH = 6'h21, T_LW = 6'h23, T_LBU = 6'h24,
                          T_LHU = 6'h25, T_SB = 6'h28, T_SH = 6'h29, T_SW = 6'h2B;
   localparam logic [31:0] JUNK = 32'hDEADBEEF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  opM = '0;
   logic        memenM = 1'b0;
   logic [31:0] aluoutM = '0;
   logic [31:0] writedataM = '0;
   logic        flushM = 1'b0;
   logic        stall_otherM = 1'b0;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_wdata;
   logic        data_addr_ok = 1'b0;
   logic        data_data_ok = 1'b0;
   logic [31:0] data_rdata = '0;
   logic        stallM;
   logic [31:0] readdataM;
   logic        adelM, adesM;

   int checks = 0;
   int errors = 0;
   logic [31:0] last_rd = '0;

   data_mem_ctrl #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .opM(opM), .memenM(memenM), .aluoutM(aluoutM),
      .writedataM(writedataM), .flushM(flushM), .stall_otherM(stall_otherM),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .stallM(stallM), .readdataM(readdataM), .adelM(adelM), .adesM(adesM)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int unsigned op_bytes(input logic [5:0] op);
      if (op == T_LB || op == T_LBU || op == T_SB) return 1;
      if (op == T_LH || op == T_LHU || op == T_SH) return 2;
      return 4;
   endfunction

   function automatic bit op_store(input logic [5:0] op);
      return op == T_SB || op == T_SH || op == T_SW;
   endfunction

   function automatic bit op_signed(input logic [5:0] op);
      return op == T_LB || op == T_LH;
   endfunction

   function automatic logic [31:0] m_size(input int unsigned n);
      return (n == 1) ? 32'd0 : (n == 2) ? 32'd1 : 32'd2;
   endfunction

   function automatic logic [31:0] m_strobe(input logic [5:0] op, input logic [31:0] a);
      logic [31:0] s;
      if (!op_store(op)) return 32'd0;
      s = ((32'd1 << op_bytes(op)) - 32'd1) << (a % 4);
      return s & 32'hF;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [5:0] op, input logic [31:0] wd);
      int unsigned n = op_bytes(op);
      if (n == 1) return (wd & 32'hFF) * 32'h01010101;
      if (n == 2) return (wd & 32'hFFFF) * 32'h00010001;
      return wd;
   endfunction

   function automatic logic [31:0] m_load(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rd);
      int unsigned n = op_bytes(op);
      logic [31:0] v, mask;
      if (n == 4) return rd;
      v    = rd >> (8 * (a % 4));
      mask = (32'd1 << (8 * n)) - 32'd1;
      v    = v & mask;
      if (op_signed(op) && v[8*n-1]) v = v | ~mask;
      return v;
   endfunction

   // One access: fl 0 none, 1 flush in first REQ cycle, 2 flush in first WAIT cycle
   task automatic run_access(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rd, input int unsigned adly, input int unsigned ddly,
                             input int unsigned fl, input int unsigned hold_extra);
      int unsigned n = op_bytes(op);
      bit st = op_store(op);
      bit mis = (a % n) != 0;
      int unsigned req_cnt = 0;
      int unsigned stall_cnt = 0;
      logic [31:0] exp_rd;

      @(negedge clk);
      opM = op; aluoutM = a; writedataM = wd; memenM = 1'b1; flushM = 1'b0;
      stall_otherM = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = JUNK;
      #1;
      chk("adelM", adelM, 32'(mis && !st));
      chk("adesM", adesM, 32'(mis && st));
      if (mis) begin
         chk("err_stallM", stallM, 0);
         chk("err_req", data_req, 0);
         for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            chk("err_stallM", stallM, 0);
            chk("err_req", data_req, 0);
         end
         memenM = 1'b0;
         return;
      end
      chk("start_stallM", stallM, 1);
      chk("start_req", data_req, 0);
      stall_cnt += 32'(stallM);

      for (int unsigned k = 0; k <= adly; k++) begin
         @(negedge clk);
         data_addr_ok = (k == adly);
         data_data_ok = (k == adly) && (ddly == 0);
         data_rdata   = data_data_ok ? rd : JUNK;
         flushM       = (fl == 1) && (k == 0);
         #1;
         req_cnt   += 32'(data_req);
         stall_cnt += 32'(stallM);
         chk("req_wr", data_wr, 32'(st));
         chk("req_size", data_size, m_size(n));
         chk("req_addr", data_addr, a);
         chk("req_wstrb", data_wstrb, m_strobe(op, a));
         if (st) chk("req_wdata", data_wdata, m_wdata(op, wd));
      end
      for (int unsigned m = 1; m <= ddly; m++) begin
         @(negedge clk);
         data_addr_ok = 1'b0;
         data_data_ok = (m == ddly);
         data_rdata   = data_data_ok ? rd : JUNK;
         flushM       = (fl == 2) && (m == 1);
         #1;
         stall_cnt += 32'(stallM);
         chk("wait_req", data_req, 0);
      end

      @(negedge clk);
      data_addr_ok = 1'b0; data_data_ok = 1'b0; flushM = 1'b0; data_rdata = JUNK;
      chk("req_cycles", req_cnt, adly + 1);
      chk("stall_cycles", stall_cnt, 2 + adly + ddly);

      if (fl != 0) begin
         memenM = 1'b0; stall_otherM = 1'b1;
         #1;
         chk("flush_rd_kept", readdataM, last_rd);
         chk("flush_stallM", stallM, 0);
         chk("flush_req", data_req, 0);
         @(negedge clk);
         memenM = 1'b1; opM = T_LW; aluoutM = 32'h0; stall_otherM = 1'b0;
         #1;
         chk("flush_no_hold", stallM, 1);
         memenM = 1'b0;
         return;
      end

      exp_rd  = st ? last_rd : m_load(op, a, rd);
      last_rd = exp_rd;
      stall_otherM = (hold_extra > 0);
      #1;
      chk("hold_rd", readdataM, exp_rd);
      chk("hold_stallM", stallM, 0);
      chk("hold_req", data_req, 0);
      for (int unsigned h = 1; h <= hold_extra; h++) begin
         @(negedge clk);
         stall_otherM = (h < hold_extra);
         #1;
         chk("hold_rd_stable", readdataM, exp_rd);
         chk("hold_stallM", stallM, 0);
         chk("hold_no_req", data_req, 0);
      end
   endtask

   initial begin
      logic [5:0] ops [8];
      ops = '{T_LB, T_LH, T_LW, T_LBU, T_LHU, T_SB, T_SH, T_SW};

      // reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req", data_req, 0);
      chk("rst_wr", data_wr, 0);
      chk("rst_size", data_size, 0);
      chk("rst_addr", data_addr, 0);
      chk("rst_wstrb", data_wstrb, 0);
      chk("rst_wdata", data_wdata, 0);
      chk("rst_rd", readdataM, 0);
      chk("rst_stallM", stallM, 0);
      rst = 1'b0;

      // directed vectors
      run_access(T_SB,  32'h00001003, 32'h000000AB, JUNK,         0, 1, 0, 0);
      run_access(T_LB,  32'h00001002, 32'h0,        32'h00800000, 0, 1, 0, 0);
      chk("lb_const", readdataM, 32'hFFFFFF80);
      run_access(T_LBU, 32'h00001002, 32'h0,        32'h00800000, 0, 1, 0, 0);
      chk("lbu_const", readdataM, 32'h00000080);
      run_access(T_LH,  32'h00001002, 32'h0,        32'h80010000, 0, 0, 0, 0);
      chk("lh_const", readdataM, 32'hFFFF8001);
      run_access(T_LW,  32'h00001002, 32'h0,        32'h12345678, 0, 1, 0, 0);
      run_access(T_SH,  32'h00001001, 32'h5555AAAA, JUNK,         0, 1, 0, 0);
      run_access(T_LW,  32'h00002000, 32'h0,        32'hCAFEF00D, 3, 2, 0, 0);
      run_access(T_LHU, 32'h00003002, 32'h0,        32'h7FFF1234, 0, 2, 2, 0);
      run_access(T_SW,  32'h00003004, 32'h01020304, JUNK,         1, 0, 1, 0);
      run_access(T_LW,  32'h00004008, 32'h0,        32'hA5A55A5A, 0, 1, 0, 2);

      // randomized accesses
      for (int it = 0; it < 60; it++) begin
         logic [5:0]  op;
         logic [31:0] a;
         int unsigned adly, ddly, fl;
         op = ops[$urandom_range(0, 7)];
         a  = $urandom;
         if ($urandom_range(0, 2) != 0) a = a & ~(32'(op_bytes(op)) - 32'd1);
         adly = $urandom_range(0, 3);
         ddly = $urandom_range(0, 3);
         fl   = 0;
         if (ddly > 0 && $urandom_range(0, 5) == 0) fl = 2;
         else if ($urandom_range(0, 7) == 0)        fl = 1;
         run_access(op, a, $urandom, $urandom, adly, ddly, fl, $urandom_range(0, 2));
      end

      // reset in the middle of a request
      @(negedge clk);
      opM = T_LW; aluoutM = 32'h00005000; writedataM = 32'h0; memenM = 1'b1;
      stall_otherM = 1'b0; flushM = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
      @(negedge clk);
      #1;
      chk("pre_rst_req", data_req, 1);
      rst = 1'b1; memenM = 1'b0;
      #1;
      chk("midrst_req", data_req, 0);
      chk("midrst_wr", data_wr, 0);
      chk("midrst_size", data_size, 0);
      chk("midrst_addr", data_addr, 0);
      chk("midrst_wstrb", data_wstrb, 0);
      chk("midrst_wdata", data_wdata, 0);
      chk("midrst_rd", readdataM, 0);
      chk("midrst_stallM", stallM, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk("post_rst_req", data_req, 0);
      chk("post_rst_stallM", stallM, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
